softex_tcdm_responder: RTL

// - Multi-port TCDM slave (memory + response logic) answering the accelerator's MP-port TCDM master.
// - Serves word reads/writes from a local array, returns read data with echoed ID, injects random grant stalls.
// - Used as the memory-side counterpart of the accelerator wrapper in block-level benches and FPGA bring-up.

---
 rtl/softex_tcdm_responder_if.sv | 33 +++
 rtl/softex_tcdm_responder.sv | 100 ++++++++++
 2 files changed

// File: rtl/softex_tcdm_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// softex_tcdm_responder_if: MP-port TCDM request/response bundle
// Revision: 1.0
// ============================================================================
interface softex_tcdm_responder_if #(
  parameter int MP   = 2,
  parameter int ID_W = 8
);
  logic [MP-1:0]           req;
  logic [MP-1:0]           gnt;
  logic [MP-1:0][31:0]     add;
  logic [MP-1:0]           wen;
  logic [MP-1:0][3:0]      be;
  logic [MP-1:0][31:0]     data;
  logic [MP-1:0][ID_W-1:0] id;
  logic [MP-1:0]           r_ready;
  logic [MP-1:0][31:0]     r_data;
  logic [MP-1:0]           r_valid;
  logic [MP-1:0][ID_W-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id, r_ready,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id, r_ready,
    output gnt, r_data, r_valid, r_id
  );
endinterface
`default_nettype wire

// File: rtl/softex_tcdm_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// softex_tcdm_responder: MP-port TCDM slave memory with per-port response FIFOs
// Revision: 1.0
// ============================================================================
module softex_tcdm_responder #(
  parameter int          MP        = 2,
  parameter int          NWORDS    = 1024,
  parameter int          ID_W      = 8,
  parameter int          RSP_DEPTH = 2,
  parameter int          STALL_EN  = 0,
  parameter logic [15:0] LFSR_SEED = 16'h0001
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  softex_tcdm_responder_if.slave tcdm
);

  localparam int            AW      = $clog2(NWORDS);
  localparam int            PW      = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int            CW      = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);

  logic [31:0]           mem [NWORDS];
  logic [MP-1:0]         wr;
  logic [MP-1:0][AW-1:0] idx;

  for (genvar p = 0; p < MP; p++) begin : g_port
    logic [15:0]     lfsr;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [31:0]     fdata [RSP_DEPTH];
    logic [ID_W-1:0] fid   [RSP_DEPTH];
    logic            stall;
    logic            gnt;
    logic            push;
    logic            pop;
    logic            unused_add_bits;

    assign idx[p]          = tcdm.add[p][AW+1:2];
    assign unused_add_bits = ^{tcdm.add[p][31:AW+2], tcdm.add[p][1:0]};

    // Grant depends only on registered state and the request, never on r_ready.
    assign stall = (STALL_EN != 0) && lfsr[0] && lfsr[1];
    assign gnt   = ~rst_i & tcdm.req[p] & (cnt < DEPTH_C) & ~stall;
    assign push  = gnt & tcdm.wen[p];
    assign pop   = tcdm.r_valid[p] & tcdm.r_ready[p];
    assign wr[p] = gnt & ~tcdm.wen[p];

    assign tcdm.gnt[p]     = gnt;
    assign tcdm.r_valid[p] = (cnt != '0);
    assign tcdm.r_data[p]  = fdata[head];
    assign tcdm.r_id[p]    = fid[head];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        lfsr <= LFSR_SEED ^ 16'(p + 1);
        cnt  <= '0;
        head <= '0;
        tail <= '0;
        for (int i = 0; i < RSP_DEPTH; i++) begin
          fdata[i] <= '0;
          fid[i]   <= '0;
        end
      end else begin
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        // Non-blocking read of mem yields the pre-write word on same-cycle conflicts.
        if (push) begin
          fdata[tail] <= mem[idx[p]];
          fid[tail]   <= tcdm.id[p];
          tail        <= (tail == LAST_C) ? '0 : tail + 1'b1;
        end
        if (pop) begin
          head <= (head == LAST_C) ? '0 : head + 1'b1;
        end
        if (push && !pop) begin
          cnt <= cnt + 1'b1;
        end else if (pop && !push) begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Later loop iterations override earlier ones, so the highest port wins per byte.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (wr[p] && tcdm.be[p][b]) begin
          mem[idx[p]][8*b +: 8] <= tcdm.data[p][8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
